// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: word reads into a halfword queue, V850 length decode, decode handshake.
// Optional FETCH_CTRL_PERF_EN adds fetch/starve performance counters.
module fetch_ctrl #(
    parameter logic [24:0] RESET_PC = 25'd0,
    parameter int unsigned QDEPTH   = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [23:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [63:0] inst_o,
    output logic [1:0]  inst_len,
    output logic [24:0] inst_pc,
    input  logic        redirect_i,
    input  logic [24:0] redirect_pc_i
`ifdef FETCH_CTRL_PERF_EN
    ,
    output logic [31:0] perf_fetch_cnt,
    output logic [31:0] perf_starve_cnt
`endif
);

    localparam int unsigned PW = $clog2(QDEPTH);
    localparam int unsigned CW = PW + 1;

    localparam logic [1:0] M_IDLE = 2'd0;
    localparam logic [1:0] M_REQ  = 2'd1;
    localparam logic [1:0] M_RESP = 2'd2;
    localparam logic [1:0] M_DROP = 2'd3;

    logic [1:0]    state;
    logic          stale;
    logic [23:0]   addr_q;
    logic [24:0]   fpc;
    logic [24:0]   pc_q;
    logic [PW-1:0] head;
    logic [CW-1:0] count;
    logic [15:0]   q [QDEPTH];

    logic [15:0]   h0, h1, h2, h3;
    logic [5:0]    opcode;
    logic [4:0]    reg2;
    logic [1:0]    len;
    logic [CW-1:0] len_hw;
    logic [CW-1:0] free;
    logic [CW-1:0] fill_n;
    logic [PW-1:0] tail, tail1;
    logic          fill, pop, issue;

    assign h0     = q[head];
    assign h1     = q[head + PW'(1)];
    assign h2     = q[head + PW'(2)];
    assign h3     = q[head + PW'(3)];
    assign opcode = h0[10:5];
    assign reg2   = h0[15:11];

    always_comb begin
        len = 2'd0;
        if (reg2 == 5'd0 && opcode == 6'b111111)
            len = 2'd3;
        else if (reg2 == 5'd0 && (opcode == 6'b110001 || opcode == 6'b010111))
            len = 2'd2;
        else if (h0[10:9] == 2'b11)
            len = 2'd1;
    end

    assign len_hw = CW'(len) + CW'(1);
    assign free   = CW'(QDEPTH) - count;
    assign issue  = free >= CW'(2);
    assign fill_n = fpc[0] ? CW'(1) : CW'(2);
    assign tail   = head + count[PW-1:0];
    assign tail1  = tail + PW'(1);

    // Redirect masks valid, pop and fill in the same cycle so nothing stale escapes.
    assign inst_valid = (count >= len_hw) && !redirect_i;
    assign pop        = inst_valid && inst_ready;
    assign fill       = (state == M_RESP) && imem_rvalid && !redirect_i;

    always_comb begin
        inst_o = '0;
        if (inst_valid) begin
            inst_o[63:48] = h0;
            if (len >= 2'd1) inst_o[47:32] = h1;
            if (len >= 2'd2) inst_o[31:16] = h2;
            if (len == 2'd3) inst_o[15:0]  = h3;
        end
    end

    assign inst_len  = len;
    assign inst_pc   = pc_q;
    assign imem_req  = (state == M_REQ);
    assign imem_addr = addr_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= M_IDLE;
            stale  <= 1'b0;
            addr_q <= RESET_PC[24:1];
            fpc    <= RESET_PC;
            pc_q   <= RESET_PC;
            head   <= '0;
            count  <= '0;
            for (int unsigned i = 0; i < QDEPTH; i++) q[i] <= '0;
        end else begin
            case (state)
                M_IDLE: begin
                    if (!redirect_i && issue) begin
                        state  <= M_REQ;
                        addr_q <= fpc[24:1];
                    end
                end
                M_REQ: begin
                    // A redirect before the grant must keep the request stable; remember to discard it.
                    if (imem_gnt) begin
                        state <= (stale || redirect_i) ? M_DROP : M_RESP;
                        stale <= 1'b0;
                    end else if (redirect_i) begin
                        stale <= 1'b1;
                    end
                end
                M_RESP: begin
                    if (imem_rvalid)
                        state <= M_IDLE;
                    else if (redirect_i)
                        state <= M_DROP;
                end
                M_DROP: begin
                    if (imem_rvalid) state <= M_IDLE;
                end
                default: state <= M_IDLE;
            endcase

            if (redirect_i) begin
                fpc   <= redirect_pc_i;
                pc_q  <= redirect_pc_i;
                head  <= '0;
                count <= '0;
            end else begin
                if (fill) begin
                    fpc <= {fpc[24:1] + 24'd1, 1'b0};
                    if (fpc[0]) begin
                        q[tail] <= imem_rdata[31:16];
                    end else begin
                        q[tail]  <= imem_rdata[15:0];
                        q[tail1] <= imem_rdata[31:16];
                    end
                end
                if (pop) begin
                    head <= head + len_hw[PW-1:0];
                    pc_q <= pc_q + 25'(len_hw);
                end
                count <= count + (fill ? fill_n : CW'(0)) - (pop ? len_hw : CW'(0));
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n && fill) assert (count + fill_n <= CW'(QDEPTH));
    end

`ifdef FETCH_CTRL_PERF_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            perf_fetch_cnt  <= '0;
            perf_starve_cnt <= '0;
        end else begin
            if (fill) perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
            if (inst_ready && !inst_valid && !redirect_i)
                perf_starve_cnt <= perf_starve_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed self-checking bench for fetch_ctrl: fill, length decode, stall, redirect and drop paths.
module tb_fetch_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req;
    logic [23:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        inst_valid;
    logic        inst_ready;
    logic [63:0] inst_o;
    logic [1:0]  inst_len;
    logic [24:0] inst_pc;
    logic        redirect_i;
    logic [24:0] redirect_pc_i;

    int unsigned n_assert = 0;
    int unsigned n_fail   = 0;

    bit          pend;
    logic [23:0] gaddr;

    fetch_ctrl #(.RESET_PC(25'd0), .QDEPTH(8)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_gnt      (imem_gnt),
        .imem_rvalid   (imem_rvalid),
        .imem_rdata    (imem_rdata),
        .inst_valid    (inst_valid),
        .inst_ready    (inst_ready),
        .inst_o        (inst_o),
        .inst_len      (inst_len),
        .inst_pc       (inst_pc),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_assert++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic wait_req(input string tag);
        int unsigned n = 0;
        while (!imem_req && n < 16) begin
            tick();
            n++;
        end
        check({tag, "_req"}, 64'(imem_req), 64'd1);
    endtask

    task automatic fetch(input string tag, input logic [23:0] exp_addr, input logic [31:0] data);
        wait_req(tag);
        check({tag, "_addr"}, 64'(imem_addr), 64'(exp_addr));
        imem_gnt = 1'b1;
        tick();
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b1;
        imem_rdata  = data;
        tick();
        imem_rvalid = 1'b0;
    endtask

    task automatic pop();
        inst_ready = 1'b1;
        tick();
        inst_ready = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;
    endtask

    function automatic logic [31:0] word(input logic [23:0] a);
        logic [15:0] lo;
        lo = 16'h2000 + 16'(a) * 16'd2;
        return {lo + 16'd1, lo};
    endfunction

    initial begin
        rst_n = 1'b0; imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
        inst_ready = 1'b0; redirect_i = 1'b0; redirect_pc_i = '0;

        // Reset values
        repeat (3) tick();
        check("rst_req",   64'(imem_req),   64'd0);
        check("rst_addr",  64'(imem_addr),  64'd0);
        check("rst_valid", 64'(inst_valid), 64'd0);
        check("rst_inst",  inst_o,          64'd0);
        check("rst_len",   64'(inst_len),   64'd0);
        check("rst_pc",    64'(inst_pc),    64'd0);
        rst_n = 1'b1;
        tick();
        check("first_req", 64'(imem_req), 64'd1);

        // Test 1: 16-bit instructions
        fetch("t1w0", 24'd0, 32'h0000_1234);
        check("t1_valid", 64'(inst_valid), 64'd1);
        check("t1_inst",  inst_o,          64'h1234_0000_0000_0000);
        check("t1_len",   64'(inst_len),   64'd0);
        check("t1_pc",    64'(inst_pc),    64'd0);
        fetch("t1w1", 24'd1, 32'h0000_4321);
        pop();
        check("t1_pc1",   64'(inst_pc), 64'd1);
        check("t1_inst1", inst_o,       64'd0);
        pop();
        check("t1_pc2",    64'(inst_pc),    64'd2);
        check("t1_valid2", 64'(inst_valid), 64'd1);
        check("t1_inst2",  inst_o,          64'h4321_0000_0000_0000);

        // Test 2: 32-bit ANDI
        do_reset();
        fetch("t2", 24'd0, 32'h000B_06C1);
        check("t2_valid", 64'(inst_valid), 64'd1);
        check("t2_len",   64'(inst_len),   64'd1);
        check("t2_inst",  inst_o,          64'h06C1_000B_0000_0000);
        check("t2_pc",    64'(inst_pc),    64'd0);
        pop();
        check("t2_pc_next",  64'(inst_pc),    64'd2);
        check("t2_valid_no", 64'(inst_valid), 64'd0);

        // Test 3: 48-bit
        do_reset();
        fetch("t3w0", 24'd0, 32'hBEEF_0620);
        check("t3_partial", 64'(inst_valid), 64'd0);
        fetch("t3w1", 24'd1, 32'h1111_CAFE);
        check("t3_valid", 64'(inst_valid), 64'd1);
        check("t3_len",   64'(inst_len),   64'd2);
        check("t3_inst",  inst_o,          64'h0620_BEEF_CAFE_0000);
        check("t3_pc",    64'(inst_pc),    64'd0);
        pop();
        check("t3_pc3",   64'(inst_pc),  64'd3);
        check("t3_inst3", inst_o,        64'h1111_0000_0000_0000);
        check("t3_len3",  64'(inst_len), 64'd0);
        pop();
        check("t3_pc4", 64'(inst_pc), 64'd4);

        // Test 4: decode stalled, queue fills to QDEPTH
        pend = 1'b0;
        gaddr = '0;
        for (int c = 0; c < 24; c++) begin
            imem_rvalid = pend;
            imem_rdata  = word(gaddr);
            imem_gnt    = imem_req;
            if (imem_req) gaddr = imem_addr;
            pend = imem_req;
            if (c >= 3) check("t4_hold", inst_o, 64'h2004_0000_0000_0000);
            tick();
        end
        imem_gnt = 1'b0;
        imem_rvalid = 1'b0;
        check("t4_req_full", 64'(imem_req),   64'd0);
        check("t4_valid",    64'(inst_valid), 64'd1);
        check("t4_pc",       64'(inst_pc),    64'd4);
        for (int i = 0; i < 8; i++) begin
            check("t4_drain_pc",   64'(inst_pc), 64'(4 + i));
            check("t4_drain_inst", inst_o,       {16'h2004 + 16'(i), 48'h0});
            pop();
        end
        check("t4_empty", 64'(inst_valid), 64'd0);

        // Test 5: redirect while response outstanding
        wait_req("t5a");
        check("t5a_addr", 64'(imem_addr), 64'd6);
        imem_gnt = 1'b1;
        tick();
        imem_gnt = 1'b0;
        redirect_i = 1'b1;
        redirect_pc_i = 25'd5;
        tick();
        redirect_i = 1'b0;
        check("t5_drop_req", 64'(imem_req), 64'd0);
        check("t5_pc",       64'(inst_pc),  64'd5);
        imem_rvalid = 1'b1;
        imem_rdata  = 32'hDEAD_DEAD;
        tick();
        imem_rvalid = 1'b0;
        check("t5_stale", 64'(inst_valid), 64'd0);
        fetch("t5b", 24'd2, 32'h0042_7777);
        check("t5_valid", 64'(inst_valid), 64'd1);
        check("t5_inst",  inst_o,          64'h0042_0000_0000_0000);
        check("t5_pc2",   64'(inst_pc),    64'd5);

        // Test 6: redirect coincident with rvalid and ready
        wait_req("t6a");
        check("t6a_addr", 64'(imem_addr), 64'd3);
        imem_gnt = 1'b1;
        tick();
        imem_gnt = 1'b0;
        imem_rvalid = 1'b1;
        imem_rdata  = 32'h1234_5678;
        redirect_i = 1'b1;
        redirect_pc_i = 25'd20;
        inst_ready = 1'b1;
        #1;
        check("t6_forced", 64'(inst_valid), 64'd0);
        tick();
        imem_rvalid = 1'b0;
        redirect_i = 1'b0;
        inst_ready = 1'b0;
        check("t6_valid", 64'(inst_valid), 64'd0);
        check("t6_pc",    64'(inst_pc),    64'd20);
        fetch("t6b", 24'd10, 32'h0011_0010);
        check("t6_inst", inst_o,       64'h0010_0000_0000_0000);
        check("t6_pc2",  64'(inst_pc), 64'd20);

        // Test 7: redirect before grant keeps request stable, then drops it
        wait_req("t7a");
        check("t7a_addr", 64'(imem_addr), 64'd11);
        redirect_i = 1'b1;
        redirect_pc_i = 25'd40;
        tick();
        redirect_i = 1'b0;
        check("t7_hold_req",  64'(imem_req),   64'd1);
        check("t7_hold_addr", 64'(imem_addr),  64'd11);
        check("t7_valid",     64'(inst_valid), 64'd0);
        imem_gnt = 1'b1;
        tick();
        imem_gnt = 1'b0;
        check("t7_drop_req", 64'(imem_req), 64'd0);
        imem_rvalid = 1'b1;
        imem_rdata  = 32'hFFFF_FFFF;
        tick();
        imem_rvalid = 1'b0;
        fetch("t7b", 24'd20, 32'h0031_0030);
        check("t7_inst", inst_o,       64'h0030_0000_0000_0000);
        check("t7_pc",   64'(inst_pc), 64'd40);

        // Test 8: 64-bit instruction
        pop();
        pop();
        check("t8_pc", 64'(inst_pc), 64'd42);
        fetch("t8w0", 24'd21, 32'h0001_07E0);
        check("t8_partial", 64'(inst_valid), 64'd0);
        fetch("t8w1", 24'd22, 32'h0003_0002);
        check("t8_valid", 64'(inst_valid), 64'd1);
        check("t8_len",   64'(inst_len),   64'd3);
        check("t8_inst",  inst_o,          64'h07E0_0001_0002_0003);
        pop();
        check("t8_pc2",   64'(inst_pc),    64'd46);
        check("t8_empty", 64'(inst_valid), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/fetch_ctrl.md
# fetch_ctrl

Instruction fetch controller sitting between the 32-bit instruction memory port and the decode stage. It issues word reads, buffers fetched halfwords in a small queue, assembles variable-length V850 instructions (16/32/48/64 bits) and hands them to decode over a valid/ready handshake. It also owns the fetch PC and handles redirects from branch/exception logic, discarding stale data still in flight.

## Interface
- `RESET_PC`, 25'd0: halfword address fetched first after reset.
- `QDEPTH`, 8: queue depth in halfwords. Power of two, minimum 4.
- `clk`  in  1  clock; all state updates on rising edge.
- `rst_n`  in  1  synchronous, active-low reset.
- `imem_req`  out  1  read request; held until `imem_gnt`.
- `imem_addr`  out  24  word address (halfword PC >> 1); stable while `imem_req` high.
- `imem_gnt`  in  1  request accepted this cycle.
- `imem_rvalid`  in  1  read data valid; arrives ≥1 cycle after the granting cycle.
- `imem_rdata`  in  32  word; `[15:0]` = even halfword, `[31:16]` = odd halfword.
- `inst_valid`  out  1  complete instruction available.
- `inst_ready`  in  1  decode accepts instruction.
- `inst_o`  out  64  instruction, first halfword in `[63:48]`, following halfwords below, unused bits zero.
- `inst_len`  out  2  0=16, 1=32, 2=48, 3=64 bits.
- `inst_pc`  out  25  halfword address of the first halfword.
- `redirect_i`  in  1  flush and restart fetch.
- `redirect_pc_i`  in  25  new halfword PC.

## Operation
- Memory FSM: `M_IDLE` → `M_REQ` (req high) → on `imem_gnt` → `M_RESP` → on `imem_rvalid` → `M_IDLE`. One outstanding read max. `M_DROP`: response still owed but flushed; on `imem_rvalid` discard data → `M_IDLE`.
- Issue rule: go to `M_REQ` when free slots (QDEPTH − count) ≥ 2 and no read outstanding.
- Fill: on `imem_rvalid` in `M_RESP`, write halfwords to queue; if fetch PC odd, write only `[31:16]`. Fetch PC advances to next even halfword address.
- Length decode on head halfword h0 (opcode = h0[10:5], reg2 = h0[15:11]), first match wins:
  - reg2==0 and opcode==6'b111111 → 64-bit.
  - reg2==0 and opcode ∈ {6'b110001, 6'b010111} → 48-bit.
  - h0[10:9]==2'b11 → 32-bit.
  - else 16-bit.
- `inst_valid` = 1 when queue count ≥ decoded length in halfwords. Handshake when `inst_valid & inst_ready`: pop length halfwords, `inst_pc` advances by length.
- Redirect: queue cleared, fetch PC and `inst_pc` ← `redirect_pc_i`; FSM: `M_IDLE`→`M_IDLE`, `M_RESP`→`M_DROP`, `M_REQ`→ keep req/addr until gnt, then `M_DROP`; `M_DROP` stays.
- Queue full: never overflows by issue rule; a violation is a design error (assertion).

## Timing
- Reset values: `imem_req`=0, `imem_addr`=`RESET_PC>>1`, `inst_valid`=0, `inst_o`=0, `inst_len`=0, `inst_pc`=`RESET_PC`, queue empty, FSM `M_IDLE`.
- First `imem_req` in the first cycle after `rst_n` is sampled high.
- `imem_rvalid` at edge N → `inst_valid` visible in cycle N+1 (if enough halfwords). `inst_valid`/`inst_o` are decoded from registered queue state, no combinational path from memory inputs.
- Pop and fill in the same cycle are both applied; count = count + fill − pop.
- `redirect_i` dominates: in that cycle `inst_valid` forced 0, a simultaneous `imem_rvalid` is dropped, no pop. New PC request earliest next cycle (if not `M_DROP`).
- `inst_o`/`inst_len`/`inst_pc` stable while `inst_valid & !inst_ready`.
- Reset mid-read: FSM and queue cleared; any later response from the old read is ignored (memory reset together with this block).

## Configuration
- `FETCH_CTRL_PERF_EN` defined: adds outputs `perf_fetch_cnt` (32, words received and kept) and `perf_starve_cnt` (32, cycles with `inst_ready`=1 and `inst_valid`=0); both reset to 0, wrap at 2^32, freeze during redirect cycles only for `perf_starve_cnt`.
- Undefined: ports and counters absent; behaviour otherwise identical.

## Test plan
- Reset, memory returns 0x0000_1234/0x0000_4321 words with 1-cycle latency → `imem_addr` 0,1; first instruction `inst_o[63:48]`=16'h1234, `inst_len`=0, `inst_pc`=0.
- Halfwords 16'h06C1 then 16'h000B at PC 0 (ANDI, h0[10:9]=11) → one instruction `inst_len`=1, `inst_o`=64'h06C1_000B_0000_0000, next `inst_pc`=2.
- h0=16'h0620 (reg2 0, opcode 110001) + two halfwords 16'hBEEF,16'hCAFE → `inst_len`=2, `inst_o[63:16]`=48'h0620_BEEF_CAFE, pop of 3.
- `inst_ready` held 0 for 20 cycles → queue fills to 8, `imem_req` stays 0 at count ≥7, `inst_o` stable.
- `redirect_i` with `redirect_pc_i`=25'd5 while in `M_RESP` → stale `imem_rvalid` data dropped, next `imem_addr`=2, only `[31:16]` enqueued, `inst_pc`=5.
- Redirect same cycle as `imem_rvalid` and `inst_ready`=1 → no handshake, data dropped, `inst_valid`=0 next cycle.
